div_burst_scheduler: RTL and testbench

//  Shares one programmable mod-N divider between two requesters. Each requester

---
 rtl/div_ctrl_pkg.sv | 21 ++
 rtl/mod_n_counter.sv | 40 ++++
 rtl/div_burst_scheduler.sv | 162 ++++++++++++++++
 tb/tb_div_burst_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the divider burst scheduler.
// State encoding and the smallest legal modulus.
package div_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned MIN_MOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

  function automatic logic mod_ok(input int unsigned n);
    return n >= MIN_MOD;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Mod-N counter: counts 0..N-1 while enabled.
// wrap flags the cycle whose edge returns count to 0.
module mod_n_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] N,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap  = en && !clr && (count_q == N - ONE);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/div_burst_scheduler.sv
// Round-robin scheduler sharing one mod-N divider
// between two requesters, one toggle-counted job at a time.
module div_burst_scheduler
  import div_ctrl_pkg::*;
#(
  parameter int W = 3,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_mod,
  input  logic [C-1:0] req0_cnt,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_mod,
  input  logic [C-1:0] req1_cnt,
  input  logic         abort,
  output logic         fout,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         owner,
  output logic         done,
  output logic         err,
  output logic         aborted
);

  localparam logic [C-1:0] LEFT_ONE = C'(1);

  state_e       state_q;
  logic         last_q;
  logic         owner_q;
  logic [W-1:0] mod_q;
  logic [C-1:0] left_q;
  logic         fout_q;
  logic         busy_q;
  logic         done_q;
  logic         err_q;
  logic         abrt_q;

  logic         idle;
  logic         run;
  logic         gnt0;
  logic         gnt1;
  logic         acc;
  logic         sel;
  logic [W-1:0] sel_mod;
  logic [C-1:0] sel_cnt;
  logic         cnt_en;
  logic         cnt_clr;
  logic         wrap;

  assign idle = (state_q == ST_IDLE);
  assign run  = (state_q == ST_RUN);

  // last_q names the requester served most recently; the other wins a tie.
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;

  assign acc     = req0_ready | req1_ready;
  assign sel     = ~gnt0;
  assign sel_mod = gnt0 ? req0_mod : req1_mod;
  assign sel_cnt = gnt0 ? req0_cnt : req1_cnt;

  // Abort clears the counter and suppresses a coincident wrap.
  assign cnt_en  = run & ~abort;
  assign cnt_clr = ~run | abort;

  mod_n_counter #(
    .W(W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .N     (mod_q),
    .count (count),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      mod_q   <= '0;
      left_q  <= '0;
      fout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          abrt_q <= 1'b0;
          if (acc) begin
            owner_q <= sel;
            last_q  <= sel;
            mod_q   <= sel_mod;
            left_q  <= sel_cnt;
            if (mod_ok(32'(sel_mod))) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              fout_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            abrt_q  <= 1'b1;
          end else if (wrap) begin
            fout_q <= ~fout_q;
            // left_q == 0 means a free-running job.
            if (left_q != '0) begin
              left_q <= left_q - LEFT_ONE;
            end
            if (left_q == LEFT_ONE) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          abrt_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          abrt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fout    = fout_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign done    = done_q;
  assign err     = err_q;
  assign aborted = abrt_q;

endmodule

// File: tb/tb_div_burst_scheduler.sv
// Scoreboard bench for div_burst_scheduler.
// Jobs push expectations; the done monitor pops and compares.
module tb_div_burst_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_mod;
  logic [7:0] req0_cnt;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_mod;
  logic [7:0] req1_cnt;
  logic       abort;
  logic       fout, busy, owner, done, err, aborted;
  logic [2:0] count;

  div_burst_scheduler #(.W(3), .C(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_mod   (req0_mod),
    .req0_cnt   (req0_cnt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_mod   (req1_mod),
    .req1_cnt   (req1_cnt),
    .abort      (abort),
    .fout       (fout),
    .count      (count),
    .busy       (busy),
    .owner      (owner),
    .done       (done),
    .err        (err),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit own;
    bit err;
    bit abrt;
    bit fo;
    int lat;
    int runc;
    int tog;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_tog = 0;
  int runc = 0;
  int tog = 0;
  logic [2:0] job_mod = 3'd0;
  logic busy_p = 1'b0;
  logic fout_p = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      busy_p = 1'b0;
      fout_p = fout;
      runc   = 0;
      tog    = 0;
    end else begin
      chk("rdy_excl", int'(req0_ready & req1_ready), 0);
      chk("rdy_busy", int'((req0_ready | req1_ready) & busy), 0);
      if (busy) begin
        runc++;
        chk("cnt_range", int'(count < job_mod), 1);
      end
      if (busy_p && fout != fout_p) begin
        tog++;
        chk("tog_gap", cyc - last_tog, int'(job_mod));
        last_tog = cyc;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("owner", int'(owner), int'(e.own));
          chk("err", int'(err), int'(e.err));
          chk("aborted", int'(aborted), int'(e.abrt));
          chk("fout_end", int'(fout), int'(e.fo));
          chk("cnt_done", int'(count), 0);
          chk("busy_done", int'(busy), 0);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("run_cycles", runc, e.runc);
          chk("toggles", tog, e.tog);
        end
      end
      if ((req0_valid & req0_ready) | (req1_valid & req1_ready)) begin
        acc_cyc  = cyc;
        job_mod  = req0_ready ? req0_mod : req1_mod;
        last_tog = cyc + 1;
        runc     = 0;
        tog      = 0;
      end
      busy_p = busy;
      fout_p = fout;
    end
  end

  task automatic push(input bit o, input bit er, input bit ab,
                      input bit fo, input int lat, input int rc,
                      input int tg);
    exp_t x;
    x.own  = o;
    x.err  = er;
    x.abrt = ab;
    x.fo   = fo;
    x.lat  = lat;
    x.runc = rc;
    x.tog  = tg;
    sb.push_back(x);
  endtask

  task automatic submit(input bit id, input int m, input int c);
    bit ok = 1'b0;
    if (id) begin
      req1_mod = 3'(m); req1_cnt = 8'(c); req1_valid = 1'b1;
    end else begin
      req0_mod = 3'(m); req0_cnt = 8'(c); req0_valid = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    abort = 1'b0;
    req0_valid = 1'b0; req0_mod = '0; req0_cnt = '0;
    req1_valid = 1'b0; req1_mod = '0; req1_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_fout", int'(fout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_pulses", int'({done, err, aborted}), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // contention from reset: req0 first, then req1
    push(0, 0, 0, 1, 10, 9, 3);
    push(1, 0, 0, 1, 5, 4, 1);
    fork
      submit(0, 3, 3);
      submit(1, 4, 1);
    join
    drain();

    // illegal modulus: fout must stay at 1
    push(1, 1, 0, 1, 1, 0, 0);
    submit(1, 1, 5);
    drain();

    // second contention round: req0 again
    push(0, 0, 0, 0, 5, 4, 2);
    push(1, 0, 0, 1, 4, 3, 1);
    fork
      submit(0, 2, 2);
      submit(1, 3, 1);
    join
    drain();

    // single job N=6 cnt=4
    push(0, 0, 0, 0, 25, 24, 4);
    submit(0, 6, 4);
    drain();

    // continuous job aborted after 17 RUN cycles
    push(0, 0, 1, 1, 19, 18, 3);
    submit(0, 5, 0);
    repeat (17) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    drain();

    // abort on the final-wrap edge
    push(0, 0, 1, 1, 7, 6, 1);
    submit(0, 3, 2);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    drain();

    // reset mid-run: no done, req0 priority afterwards
    submit(0, 7, 3);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_busy", int'(busy), 1);
    chk("pre_fout", int'(fout), 1);
    reset = 1'b0;
    #1;
    chk("mid_count", int'(count), 0);
    chk("mid_fout", int'(fout), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // max modulus with contention after reset
    push(0, 0, 0, 0, 15, 14, 2);
    push(1, 0, 0, 1, 7, 6, 3);
    fork
      submit(0, 7, 2);
      submit(1, 2, 3);
    join
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
